// File: rtl/vpu_ub_writer.sv
// Deskews the two VPU result lanes into {lane2, lane1} pairs and writes them to sequential UB addresses.
// Latency: one cycle from the lane-2 valid that completes a pair to its UB write; done coincides with the final write.
// Backpressure: none. Lane 1 is buffered for up to FIFO_DEPTH cycles of skew. Orphan or overflowing elements are dropped and raise sticky flags.
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   start, base_addr,      transfer kick-off; base and row count are captured when start is accepted in IDLE
//   num_rows
//   in_data_1/in_valid_1   lane-1 element stream (leads)
//   in_data_2/in_valid_2   lane-2 element stream (lags)
//   ub_wr_en/addr/data     registered UB write port
//   busy, done             transfer status; done is a one-cycle pulse
//   err_skew, err_ovf      sticky protocol error flags, cleared by the next accepted start
module vpu_ub_writer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     num_rows,
  input  logic [DATA_W-1:0]     in_data_1,
  input  logic                  in_valid_1,
  input  logic [DATA_W-1:0]     in_data_2,
  input  logic                  in_valid_2,
  output logic                  ub_wr_en,
  output logic [ADDR_W-1:0]     ub_wr_addr,
  output logic [2*DATA_W-1:0]   ub_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_skew,
  output logic                  err_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, rows_q, pair_idx_q;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    fifo_cnt_q;

  logic                fifo_empty, fifo_full;
  logic                push, pop, pair_fire, skew_hit, ovf_hit, accept_start, last_pair;
  logic [DATA_W-1:0]   pair_lo;

  assign fifo_empty   = (fifo_cnt_q == '0);
  assign fifo_full    = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign last_pair    = (pair_idx_q == rows_q - ADDR_W'(1));
  assign accept_start = (state_q == S_IDLE) && start;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pairing decision and next state. FIFO occupancy is taken from before this
  // cycle's update, so a pop from a full FIFO makes room for a simultaneous push.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pop       = 1'b0;
    pair_fire = 1'b0;
    skew_hit  = 1'b0;
    ovf_hit   = 1'b0;
    pair_lo   = in_data_1;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_rows == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (in_valid_2) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            pair_fire = 1'b1;
            pair_lo   = fifo_mem[rd_ptr_q];
            push      = in_valid_1;
          end else if (in_valid_1) begin
            // Zero skew: lane 1 pairs directly and is never stored.
            pair_fire = 1'b1;
          end else begin
            skew_hit = 1'b1;
          end
        end else if (in_valid_1) begin
          if (fifo_full) ovf_hit = 1'b1;
          else           push    = 1'b1;
        end
        if (pair_fire && last_pair) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Storage only; occupancy is tracked by the reset-controlled pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= in_data_1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      rows_q     <= '0;
      pair_idx_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ub_wr_en   <= 1'b0;
      ub_wr_addr <= '0;
      ub_wr_data <= '0;
      err_skew   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      ub_wr_en <= pair_fire;
      if (pair_fire) begin
        ub_wr_addr <= base_q + pair_idx_q;
        ub_wr_data <= {in_data_2, pair_lo};
        pair_idx_q <= pair_idx_q + ADDR_W'(1);
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      err_skew <= err_skew | skew_hit;
      err_ovf  <= err_ovf  | ovf_hit;

      if (accept_start) begin
        base_q     <= base_addr;
        rows_q     <= num_rows;
        pair_idx_q <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        fifo_cnt_q <= '0;
        err_skew   <= 1'b0;
        err_ovf    <= 1'b0;
      end else if (state_q == S_DONE) begin
        // Unpaired lane-1 leftovers do not carry into the next transfer.
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end
    end
  end

endmodule
